// File: rtl/timer_ctrl_pkg.sv
// Shared types for the timer controller: FSM state and reload mode.
package timer_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic {
    ONESHOT  = 1'b0,
    PERIODIC = 1'b1
  } mode_e;

endpackage

// File: rtl/timer_ctrl_counter.sv
// Generic up/down counter with clear > load > enable priority and a wrap flag.
module timer_ctrl_counter #(
  parameter int unsigned WIDTH           = 8,
  parameter bit          STICKY_OVERFLOW = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             clear_i,
  input  logic             down_i,
  output logic [WIDTH-1:0] count_o,
  output logic             overflow_o
);

  logic wrap;

  assign wrap = en_i && !load_i && !clear_i &&
                (down_i ? (count_o == '0) : (count_o == '1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_o    <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (clear_i)     count_o <= '0;
      else if (load_i) count_o <= load_val_i;
      else if (en_i)   count_o <= down_i ? count_o - WIDTH'(1) : count_o + WIDTH'(1);

      if (clear_i)              overflow_o <= 1'b0;
      else if (STICKY_OVERFLOW) overflow_o <= overflow_o | wrap;
      else                      overflow_o <= wrap;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Prescaled down-counting timer with one-shot/periodic modes and a valid/ready expiry event.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned PRESC_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cfg_valid_i,
  output logic                   cfg_ready_o,
  input  logic [WIDTH-1:0]       cfg_period_i,
  input  logic [PRESC_WIDTH-1:0] cfg_presc_i,
  input  logic                   cfg_periodic_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  output logic                   evt_valid_o,
  input  logic                   evt_ready_i,
  output logic                   evt_missed_o,
  output logic                   busy_o,
  output logic [WIDTH-1:0]       count_o
);

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       period_q;
  logic [PRESC_WIDTH-1:0] presc_q;
  mode_e                  mode_q;

  logic [WIDTH-1:0]       reload_val;
  logic [PRESC_WIDTH-1:0] presc_cnt;
  logic in_run, cfg_hs, stop_run, start_acc, tick, expiry, periodic;
  logic cnt_load, cnt_clear, presc_clear;
  logic evt_valid_q, evt_missed_q;
  logic cnt_ovf_unused, presc_ovf_unused;

  assign in_run     = (state_q == RUN);
  assign cfg_hs     = cfg_valid_i && !in_run;
  assign stop_run   = in_run && stop_i;
  assign start_acc  = start_i && !cfg_hs && !stop_run;
  assign tick       = in_run && (presc_cnt == presc_q);
  // Expiry is the tick that finds the count already at zero, not a counter wrap.
  assign expiry     = tick && (count_o == '0);
  assign periodic   = (mode_q == PERIODIC);
  assign reload_val = (period_q == '0) ? '0 : period_q - WIDTH'(1);

  assign cnt_load    = start_acc || (expiry && periodic && !stop_run);
  assign cnt_clear   = stop_run || (expiry && !periodic && !start_acc);
  assign presc_clear = tick || stop_run || start_acc;

  timer_ctrl_counter #(
    .WIDTH          (WIDTH),
    .STICKY_OVERFLOW(1'b0)
  ) u_tick_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (tick),
    .load_i    (cnt_load),
    .load_val_i(reload_val),
    .clear_i   (cnt_clear),
    .down_i    (1'b1),
    .count_o   (count_o),
    .overflow_o(cnt_ovf_unused)
  );

  timer_ctrl_counter #(
    .WIDTH          (PRESC_WIDTH),
    .STICKY_OVERFLOW(1'b0)
  ) u_presc_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (in_run),
    .load_i    (1'b0),
    .load_val_i('0),
    .clear_i   (presc_clear),
    .down_i    (1'b0),
    .count_o   (presc_cnt),
    .overflow_o(presc_ovf_unused)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      period_q     <= '0;
      presc_q      <= '0;
      mode_q       <= ONESHOT;
      evt_valid_q  <= 1'b0;
      evt_missed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cfg_hs) begin
        period_q <= cfg_period_i;
        presc_q  <= cfg_presc_i;
        mode_q   <= cfg_periodic_i ? PERIODIC : ONESHOT;
      end
      evt_valid_q <= expiry || (evt_valid_q && !evt_ready_i);
      // A clearing handshake wins over a coincident missed expiry.
      if (cfg_hs || start_acc)
        evt_missed_q <= 1'b0;
      else if (expiry && evt_valid_q && !evt_ready_i)
        evt_missed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cfg_ready_o = (state_q == IDLE);
    busy_o      = (state_q == RUN);
    unique case (state_q)
      IDLE: if (start_acc) state_d = RUN;
      RUN: begin
        if (stop_run)                              state_d = IDLE;
        else if (!start_acc && expiry && !periodic) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign evt_valid_o  = evt_valid_q;
  assign evt_missed_o = evt_missed_q;

endmodule
